ifu: RTL and testbench

- Instruction fetch unit: the producer side of the IF→DEC valid/ready interface.
- Generates sequential fetch addresses and issues them to the instruction memory port. Pairs in-order responses with their PCs in a small ring buffer, then presents one instruction per cycle to the decode stage.
- Handles pipeline flush with redirect. Responses still in flight at a flush are discarded.

---
 rtl/ifu_if.sv | 28 ++
 rtl/ifu.sv | 100 ++++++++++
 tb/tb_ifu.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/ifu_if.sv
// IF-stage bus bundle: instruction-memory request/response and the IF->DEC valid/ready handoff.
interface ifu_if;
  logic [63:0] im_req_addr;
  logic        im_req_valid;
  logic        im_req_ready;
  logic [31:0] im_resp_rdata;
  logic        im_resp_valid;
  logic [63:0] if_dec_pc;
  logic [31:0] if_dec_instr;
  logic        if_dec_bp;
  logic [63:0] if_dec_bt;
  logic        if_dec_valid;
  logic        if_dec_ready;

  modport master (
    output im_req_addr, im_req_valid,
    input  im_req_ready, im_resp_rdata, im_resp_valid,
    output if_dec_pc, if_dec_instr, if_dec_bp, if_dec_bt, if_dec_valid,
    input  if_dec_ready
  );

  modport slave (
    input  im_req_addr, im_req_valid,
    output im_req_ready, im_resp_rdata, im_resp_valid,
    input  if_dec_pc, if_dec_instr, if_dec_bp, if_dec_bt, if_dec_valid,
    output if_dec_ready
  );
endinterface

// File: rtl/ifu.sv
// Instruction fetch unit: sequential PC generation, in-order response pairing in a ring,
// and flush/redirect with discard of responses still in flight.
module ifu #(
  parameter logic [63:0] RESET_VECTOR = 64'h0000_0000_8000_0000,
  parameter int          DEPTH        = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_flush,
  input  logic [63:0] redirect_pc,
  ifu_if.master       bus
);
  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t             ring [DEPTH];
  logic [DEPTH-1:0] filled;
  logic [63:0]      fetch_pc;
  logic [PW-1:0]    alloc_ptr, fill_ptr, read_ptr, drop_cnt;

  logic [PW-1:0] live;
  logic          full, req_fire, resp_fill, deq;
  logic [PW:0]   drop_sum;
  logic [IW-1:0] a_idx, f_idx, r_idx;

  assign a_idx     = alloc_ptr[IW-1:0];
  assign f_idx     = fill_ptr[IW-1:0];
  assign r_idx     = read_ptr[IW-1:0];
  assign live      = alloc_ptr - read_ptr;
  assign full      = (live == PW'(DEPTH));
  assign req_fire  = bus.im_req_valid && bus.im_req_ready;
  assign resp_fill = bus.im_resp_valid && (drop_cnt == '0);
  assign deq       = bus.if_dec_valid && bus.if_dec_ready;

  // A response landing in the flush cycle retires one of the older fetches, so it is
  // subtracted from what must be dropped later.
  assign drop_sum = {1'b0, drop_cnt} + {1'b0, PW'(alloc_ptr - fill_ptr)}
                  - (PW+1)'(bus.im_resp_valid);

  assign bus.im_req_valid = rst && !full && !pipe_flush;
  assign bus.im_req_addr  = {fetch_pc[63:2], 2'b00};
  assign bus.if_dec_valid = (live != '0) && filled[r_idx];
  assign bus.if_dec_pc    = ring[r_idx].pc;
  assign bus.if_dec_instr = ring[r_idx].instr;
  assign bus.if_dec_bp    = 1'b0;
  assign bus.if_dec_bt    = ring[r_idx].pc + 64'd4;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc  <= RESET_VECTOR;
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      read_ptr  <= '0;
      drop_cnt  <= '0;
      filled    <= '0;
    end else if (pipe_flush) begin
      fetch_pc  <= redirect_pc;
      alloc_ptr <= read_ptr;
      fill_ptr  <= read_ptr;
      filled    <= '0;
      drop_cnt  <= drop_sum[PW-1:0];
    end else begin
      if (req_fire) begin
        fetch_pc         <= fetch_pc + 64'd4;
        alloc_ptr        <= alloc_ptr + 1'b1;
        filled[a_idx]    <= 1'b0;
      end
      if (bus.im_resp_valid) begin
        if (drop_cnt != '0) drop_cnt <= drop_cnt - 1'b1;
        else begin
          fill_ptr      <= fill_ptr + 1'b1;
          filled[f_idx] <= 1'b1;
        end
      end
      if (deq) begin
        read_ptr      <= read_ptr + 1'b1;
        filled[r_idx] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) ring[i] <= '0;
    end else if (!pipe_flush) begin
      if (req_fire)  ring[a_idx].pc    <= fetch_pc;
      if (resp_fill) ring[f_idx].instr <= bus.im_resp_rdata;
    end
  end

`ifndef SYNTHESIS
  resp_has_owner: assert property (@(posedge clk) disable iff (!rst)
    bus.im_resp_valid |-> (drop_cnt != '0 || fill_ptr != alloc_ptr));
`endif
endmodule

// File: tb/tb_ifu.sv
// Directed bench for ifu: reset, streaming, decode backpressure, memory stall, flush/discard, mid-stream reset.
module tb_ifu;
  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_flush;
  logic [63:0] redirect_pc;
  ifu_if bus();

  ifu dut (.clk(clk), .rst(rst), .pipe_flush(pipe_flush), .redirect_pc(redirect_pc), .bus(bus.master));

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    logic [63:0] bt;
    logic        bp;
  } dec_t;

  int          checks = 0;
  int          errors = 0;
  bit          auto_mem = 0;
  dec_t        dec_q[$];
  logic [63:0] req_q[$];

  // Memory returns a PC-tagged word so pairing mistakes are visible.
  function automatic logic [31:0] instr_of(input logic [63:0] a);
    return {a[15:0], 16'h0013};
  endfunction

  // One clock: log handshakes seen before the edge, then (auto mode) answer last cycle's request.
  task automatic step();
    bit          hs;
    logic [63:0] a;
    dec_t        d;
    #2;
    hs = bus.im_req_valid && bus.im_req_ready;
    a  = bus.im_req_addr;
    if (hs) req_q.push_back(a);
    if (bus.if_dec_valid && bus.if_dec_ready) begin
      d.pc = bus.if_dec_pc; d.instr = bus.if_dec_instr; d.bt = bus.if_dec_bt; d.bp = bus.if_dec_bp;
      dec_q.push_back(d);
    end
    @(posedge clk);
    #1;
    if (auto_mem) begin
      bus.im_resp_valid = hs;
      bus.im_resp_rdata = hs ? instr_of(a) : 32'h0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; pipe_flush = 1'b0; redirect_pc = '0; auto_mem = 0;
    bus.im_req_ready = 1'b0; bus.im_resp_valid = 1'b0; bus.im_resp_rdata = '0; bus.if_dec_ready = 1'b0;
    step(); step();
    dec_q.delete(); req_q.delete();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; pipe_flush = 1'b0; redirect_pc = '0;
    bus.im_req_ready = 1'b1; bus.im_resp_valid = 1'b0; bus.im_resp_rdata = '0; bus.if_dec_ready = 1'b1;
    #1;
    checks++; if (bus.im_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid got %b want 0", bus.im_req_valid); end
    checks++; if (bus.if_dec_valid !== 1'b0) begin errors++; $display("FAIL rst_dec_valid got %b want 0", bus.if_dec_valid); end
    checks++; if (bus.if_dec_pc !== 64'h0) begin errors++; $display("FAIL rst_dec_pc got %h want 0", bus.if_dec_pc); end
    checks++; if (bus.if_dec_instr !== 32'h0) begin errors++; $display("FAIL rst_dec_instr got %h want 0", bus.if_dec_instr); end
    checks++; if (bus.if_dec_bt !== 64'h4) begin errors++; $display("FAIL rst_dec_bt got %h want 4", bus.if_dec_bt); end
    step(); step();
    rst = 1'b1;
    #1;
    checks++; if (bus.im_req_valid !== 1'b1) begin errors++; $display("FAIL rel_req_valid got %b want 1", bus.im_req_valid); end
    checks++; if (bus.im_req_addr !== 64'h8000_0000) begin errors++; $display("FAIL rel_req_addr got %h want 80000000", bus.im_req_addr); end
  endtask

  task automatic test_stream();
    logic [63:0] pc;
    do_reset();
    bus.im_req_ready = 1'b1; bus.if_dec_ready = 1'b1; auto_mem = 1;
    repeat (10) step();
    bus.im_req_ready = 1'b0;
    repeat (5) step();
    checks++; if (dec_q.size() !== 10) begin errors++; $display("FAIL stream_count got %0d want 10", dec_q.size()); end
    for (int i = 0; i < 10; i++) begin
      pc = 64'h8000_0000 + 64'(4 * i);
      checks++; if (req_q[i] !== pc) begin errors++; $display("FAIL stream_req[%0d] got %h want %h", i, req_q[i], pc); end
      checks++; if (dec_q[i].pc !== pc) begin errors++; $display("FAIL stream_pc[%0d] got %h want %h", i, dec_q[i].pc, pc); end
      checks++; if (dec_q[i].instr !== {pc[15:0], 16'h0013}) begin errors++; $display("FAIL stream_instr[%0d] got %h want %h", i, dec_q[i].instr, {pc[15:0], 16'h0013}); end
      checks++; if (dec_q[i].bt !== pc + 64'd4 || dec_q[i].bp !== 1'b0) begin errors++; $display("FAIL stream_bt_bp[%0d] got %h/%b want %h/0", i, dec_q[i].bt, dec_q[i].bp, pc + 64'd4); end
    end
    auto_mem = 0; bus.im_resp_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.im_req_ready = 1'b1; bus.if_dec_ready = 1'b0; auto_mem = 1;
    repeat (8) step();
    checks++; if (req_q.size() !== 4) begin errors++; $display("FAIL bp_req_count got %0d want 4", req_q.size()); end
    checks++; if (bus.im_req_valid !== 1'b0) begin errors++; $display("FAIL bp_full_valid got %b want 0", bus.im_req_valid); end
    checks++; if (bus.if_dec_valid !== 1'b1 || bus.if_dec_pc !== 64'h8000_0000) begin errors++; $display("FAIL bp_head got %b/%h want 1/80000000", bus.if_dec_valid, bus.if_dec_pc); end
    bus.if_dec_ready = 1'b1;
    repeat (12) step();
    bus.im_req_ready = 1'b0;
    repeat (4) step();
    for (int i = 0; i < 4; i++) begin
      checks++; if (dec_q[i].pc !== 64'h8000_0000 + 64'(4 * i)) begin errors++; $display("FAIL bp_drain_pc[%0d] got %h want %h", i, dec_q[i].pc, 64'h8000_0000 + 64'(4 * i)); end
    end
    checks++; if (req_q[4] !== 64'h8000_0010) begin errors++; $display("FAIL bp_resume_req got %h want 80000010", req_q[4]); end
    checks++; if (dec_q[4].pc !== 64'h8000_0010 || dec_q[4].instr !== 32'h0010_0013) begin errors++; $display("FAIL bp_resume_dec got %h/%h want 80000010/00100013", dec_q[4].pc, dec_q[4].instr); end
    auto_mem = 0; bus.im_resp_valid = 1'b0;
  endtask

  task automatic test_req_stall();
    do_reset();
    bus.im_req_ready = 1'b0; bus.if_dec_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (bus.im_req_valid !== 1'b1 || bus.im_req_addr !== 64'h8000_0000) begin errors++; $display("FAIL stall_hold[%0d] got %b/%h want 1/80000000", i, bus.im_req_valid, bus.im_req_addr); end
    end
    checks++; if (req_q.size() !== 0 || bus.if_dec_valid !== 1'b0) begin errors++; $display("FAIL stall_no_alloc got %0d/%b want 0/0", req_q.size(), bus.if_dec_valid); end
    bus.im_req_ready = 1'b1;
    step();
    checks++; if (req_q[0] !== 64'h8000_0000 || bus.im_req_addr !== 64'h8000_0004) begin errors++; $display("FAIL stall_release got %h/%h want 80000000/80000004", req_q[0], bus.im_req_addr); end
  endtask

  task automatic test_flush();
    do_reset();
    bus.im_req_ready = 1'b1; bus.if_dec_ready = 1'b1;
    step(); step();
    pipe_flush = 1'b1; redirect_pc = 64'h1000;
    #1;
    checks++; if (bus.im_req_valid !== 1'b0) begin errors++; $display("FAIL flush_no_req got %b want 0", bus.im_req_valid); end
    step();
    pipe_flush = 1'b0;
    checks++; if (bus.im_req_addr !== 64'h1000) begin errors++; $display("FAIL flush_redirect got %h want 1000", bus.im_req_addr); end
    bus.im_resp_valid = 1'b1; bus.im_resp_rdata = 32'hBAD0_0001;
    step();
    checks++; if (bus.if_dec_valid !== 1'b0) begin errors++; $display("FAIL flush_drop1 got %b want 0", bus.if_dec_valid); end
    bus.im_resp_rdata = 32'hBAD0_0002;
    step();
    checks++; if (bus.if_dec_valid !== 1'b0) begin errors++; $display("FAIL flush_drop2 got %b want 0", bus.if_dec_valid); end
    bus.im_resp_rdata = 32'h1000_0013;
    step();
    bus.im_resp_valid = 1'b0; bus.im_req_ready = 1'b0;
    step(); step();
    checks++; if (dec_q.size() !== 1) begin errors++; $display("FAIL flush_dec_count got %0d want 1", dec_q.size()); end
    checks++; if (dec_q[0].pc !== 64'h1000 || dec_q[0].instr !== 32'h1000_0013) begin errors++; $display("FAIL flush_first got %h/%h want 1000/10000013", dec_q[0].pc, dec_q[0].instr); end
    checks++; if (req_q[2] !== 64'h1000 || req_q[3] !== 64'h1004) begin errors++; $display("FAIL flush_reqs got %h/%h want 1000/1004", req_q[2], req_q[3]); end
  endtask

  task automatic test_flush_with_resp();
    do_reset();
    bus.im_req_ready = 1'b1; bus.if_dec_ready = 1'b1;
    step(); step(); step();
    pipe_flush = 1'b1; redirect_pc = 64'h2000;
    bus.im_resp_valid = 1'b1; bus.im_resp_rdata = 32'hBAD0_0001;
    step();
    pipe_flush = 1'b0; bus.im_resp_rdata = 32'hBAD0_0002;
    step();
    bus.im_resp_rdata = 32'hBAD0_0003;
    step();
    checks++; if (bus.if_dec_valid !== 1'b0) begin errors++; $display("FAIL fr_drop got %b want 0", bus.if_dec_valid); end
    bus.im_resp_rdata = 32'h2000_0013;
    step();
    bus.im_resp_valid = 1'b0; bus.im_req_ready = 1'b0;
    checks++; if (bus.if_dec_valid !== 1'b1 || bus.if_dec_bt !== 64'h2004) begin errors++; $display("FAIL fr_present got %b/%h want 1/2004", bus.if_dec_valid, bus.if_dec_bt); end
    step(); step();
    checks++; if (dec_q.size() !== 1 || dec_q[0].pc !== 64'h2000 || dec_q[0].instr !== 32'h2000_0013) begin errors++; $display("FAIL fr_first got %0d %h/%h want 1 2000/20000013", dec_q.size(), dec_q[0].pc, dec_q[0].instr); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.im_req_ready = 1'b1; bus.if_dec_ready = 1'b0;
    step();
    bus.im_resp_valid = 1'b1; bus.im_resp_rdata = 32'h0000_0013;
    step();
    bus.im_resp_valid = 1'b0;
    step(); step();
    checks++; if (bus.if_dec_valid !== 1'b1 || bus.if_dec_pc !== 64'h8000_0000) begin errors++; $display("FAIL mid_pre got %b/%h want 1/80000000", bus.if_dec_valid, bus.if_dec_pc); end
    rst = 1'b0;
    #1;
    checks++; if (bus.im_req_valid !== 1'b0 || bus.if_dec_valid !== 1'b0) begin errors++; $display("FAIL mid_valids got %b/%b want 0/0", bus.im_req_valid, bus.if_dec_valid); end
    checks++; if (bus.if_dec_pc !== 64'h0 || bus.if_dec_instr !== 32'h0 || bus.if_dec_bt !== 64'h4) begin errors++; $display("FAIL mid_outs got %h/%h/%h want 0/0/4", bus.if_dec_pc, bus.if_dec_instr, bus.if_dec_bt); end
    bus.if_dec_ready = 1'b1; auto_mem = 1;
    step(); step();
    dec_q.delete(); req_q.delete();
    rst = 1'b1;
    #1;
    checks++; if (bus.im_req_valid !== 1'b1 || bus.im_req_addr !== 64'h8000_0000) begin errors++; $display("FAIL mid_restart got %b/%h want 1/80000000", bus.im_req_valid, bus.im_req_addr); end
    repeat (4) step();
    bus.im_req_ready = 1'b0;
    repeat (3) step();
    checks++; if (dec_q.size() !== 4 || dec_q[0].pc !== 64'h8000_0000 || dec_q[0].instr !== 32'h0000_0013) begin errors++; $display("FAIL mid_no_drop got %0d %h/%h want 4 80000000/00000013", dec_q.size(), dec_q[0].pc, dec_q[0].instr); end
    auto_mem = 0; bus.im_resp_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_req_stall();
    test_flush();
    test_flush_with_resp();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
